min_hardware: RTL and testbench



---
 rtl/min_hardware.sv | 55 +++++
 tb/tb_min_hardware.sv | 134 +++++++++++++
 2 files changed

// File: rtl/min_hardware.sv
// Sobel edge detector over a 3-row window, one full row per clock, registered output (1 cycle).
// No backpressure; build with MIN_HW_GRAY_OUT_EN for a saturating gray-gradient output instead of binary.
module min_hardware #(
  parameter int WIDTH     = 320,
  parameter int THRESHOLD = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in1 [0:WIDTH-1],
  input  logic [7:0] in2 [0:WIDTH-1],
  input  logic [7:0] in3 [0:WIDTH-1],
  output logic [7:0] out [0:WIDTH-1]
);

  logic [7:0] nxt [0:WIDTH-1];

  for (genvar x = 0; x < WIDTH; x++) begin : g_lane
    if (x == 0 || x == WIDTH-1) begin : g_border
      // No padding: lanes without a full neighbourhood are never edges.
      assign nxt[x] = 8'h00;
    end else begin : g_int
      logic [9:0]         sum_r, sum_l, sum_b, sum_t;
      logic signed [10:0] gx, gy;
      logic [10:0]        ax, ay, mag;

      assign sum_r = {2'b00, in1[x+1]} + {1'b0, in2[x+1], 1'b0} + {2'b00, in3[x+1]};
      assign sum_l = {2'b00, in1[x-1]} + {1'b0, in2[x-1], 1'b0} + {2'b00, in3[x-1]};
      assign sum_b = {2'b00, in3[x-1]} + {1'b0, in3[x],   1'b0} + {2'b00, in3[x+1]};
      assign sum_t = {2'b00, in1[x-1]} + {1'b0, in1[x],   1'b0} + {2'b00, in1[x+1]};

      assign gx = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
      assign gy = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});

      // |G| <= 1020 each, so the L1 sum fits in 11 bits without overflow.
      assign ax  = gx[10] ? -gx : gx;
      assign ay  = gy[10] ? -gy : gy;
      assign mag = ax + ay;

`ifdef MIN_HW_GRAY_OUT_EN
      assign nxt[x] = (mag > 11'd255) ? 8'hFF : mag[7:0];
`else
      assign nxt[x] = (mag > 11'(THRESHOLD)) ? 8'hFF : 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) out[i] <= 8'h00;
    end else begin
      out <= nxt;
    end
  end

endmodule

// File: tb/tb_min_hardware.sv
// Directed-vector bench for min_hardware: uniform, step, threshold, horizontal edge, latency, async reset.
module tb_min_hardware;
  localparam int W = 320;

  logic       clk;
  logic       rst_n;
  logic [7:0] in1 [0:W-1];
  logic [7:0] in2 [0:W-1];
  logic [7:0] in3 [0:W-1];
  logic [7:0] out [0:W-1];

  int tests_run    = 0;
  int tests_failed = 0;

  min_hardware #(.WIDTH(W), .THRESHOLD(200)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Expected output for a given L1 gradient magnitude.
  function automatic logic [7:0] decide(input int mag);
`ifdef MIN_HW_GRAY_OUT_EN
    return (mag > 255) ? 8'hFF : 8'(mag);
`else
    return (mag > 200) ? 8'hFF : 8'h00;
`endif
  endfunction

  // Lanes lo..hi must read 'inner', every other lane must read 00.
  task automatic check_lanes(input string tag, input int lo, input int hi, input logic [7:0] inner);
    for (int x = 0; x < W; x++)
      check($sformatf("%s[%0d]", tag, x), out[x], (x >= lo && x <= hi) ? inner : 8'h00);
  endtask

  task automatic set_uniform(input logic [7:0] v);
    for (int x = 0; x < W; x++) begin
      in1[x] = v; in2[x] = v; in3[x] = v;
    end
  endtask

  task automatic set_vstep(input logic [7:0] hi);
    for (int x = 0; x < W; x++) begin
      in1[x] = (x >= 160) ? hi : 8'h00;
      in2[x] = in1[x];
      in3[x] = in1[x];
    end
  endtask

  task automatic set_hedge(input logic [7:0] bot);
    for (int x = 0; x < W; x++) begin
      in1[x] = 8'h00; in2[x] = 8'h00; in3[x] = bot;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_hedge(8'd100);
    #12;
    // Inputs would produce edges, but reset holds all lanes at zero.
    check_lanes("reset", 1, 0, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    set_uniform(8'h80);
    tick();
    check_lanes("uniform", 1, 0, 8'h00);

    // Vertical step 0->255 at x=160: Gx=1020 at lanes 159,160.
    set_vstep(8'd255);
    tick();
    check_lanes("vstep255", 159, 160, decide(1020));

    // Threshold boundary: mag = 4*step.
    set_vstep(8'd50);
    tick();
    check_lanes("vstep50", 159, 160, decide(200));

    set_vstep(8'd51);
    tick();
    check_lanes("vstep51", 159, 160, decide(204));

    // Horizontal edge: Gy=400 on every interior lane.
    set_hedge(8'd100);
    tick();
    check_lanes("hedge", 1, W-2, decide(400));

    // Latency: new inputs between edges must not reach out until the next posedge.
    @(negedge clk);
    set_uniform(8'h80);
    #1;
    check("hold[1]",   out[1],   decide(400));
    check("hold[200]", out[200], decide(400));
    tick();
    check_lanes("after_hold", 1, 0, 8'h00);

    // Asynchronous reset mid-run, asserted and checked away from any edge.
    set_hedge(8'd100);
    tick();
    check("pre_rst[50]", out[50], decide(400));
    #1;
    rst_n = 1'b0;
    #1;
    check_lanes("async_rst", 1, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_lanes("post_rst", 1, W-2, decide(400));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
